// File: rtl/uart_pkg.sv
// Shared RX/TX state encodings and timing helpers for uart_loopback_fifo.
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   function automatic int clks_per_bit(input int mhz, input int baud);
      return (mhz * 1_000_000) / baud;
   endfunction

   function automatic logic parity_bit(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full     = count_q == (AW+1)'(DEPTH);
   assign empty    = count_q == '0;
   assign pop_ok   = pop && !empty;
   // a pop in the same cycle frees the slot a full FIFO needs
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/uart_loopback_fifo.sv
// UART receiver feeding a FIFO that is replayed by a UART transmitter.
// Define UART_LOOPBACK_PARITY_EN to add a parity bit to both directions.
module uart_loopback_fifo #(
   parameter int BAUD       = 9600,
   parameter int MHZ        = 50,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          rxd,
   output logic                          txd,
   input  logic                          tx_pause,
   output logic                          rx_vld,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          tx_rdy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          frame_err,
   output logic                          parity_err
);
   import uart_pkg::*;

   localparam int CPB   = clks_per_bit(MHZ, BAUD);
   localparam int HALF  = CPB / 2;
   localparam int CNT_W = $clog2(CPB);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
   localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(DATA_BITS - 1);

   cfg_ok: assert property (@(posedge clock) PARITY_ODD inside {0, 1});

   logic rx_m_q, rx_m_d, rx_s_q, rx_s_d, rx_p_q, rx_p_d;
   logic rx_fall;

   always_comb begin
      rx_m_d = rxd;
      rx_s_d = rx_m_q;
      rx_p_d = rx_s_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_m_q <= 1'b1;
         rx_s_q <= 1'b1;
         rx_p_q <= 1'b1;
      end else begin
         rx_m_q <= rx_m_d;
         rx_s_q <= rx_s_d;
         rx_p_q <= rx_p_d;
      end
   end

   assign rx_fall = rx_p_q && !rx_s_q;

   rx_state_e              rx_state_q;
   logic [CNT_W-1:0]       rx_cnt_q;
   logic [BIT_W-1:0]       rx_bit_q;
   logic [DATA_BITS-1:0]   rx_shift_q, rx_data_q;
   logic                   rx_vld_q, frame_err_q, rx_tick;
`ifdef UART_LOOPBACK_PARITY_EN
   logic                   rx_par_bad_q, parity_err_q;
`endif

   assign rx_tick = rx_cnt_q == CNT_END;

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_data_q    <= '0;
         rx_vld_q     <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_LOOPBACK_PARITY_EN
         rx_par_bad_q <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_vld_q <= 1'b0;
         rx_cnt_q <= rx_cnt_q + CNT_W'(1);
         unique case (rx_state_q)
            RX_IDLE: begin
               rx_cnt_q <= '0;
               if (rx_fall) rx_state_q <= RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_END) begin
               rx_cnt_q   <= '0;
               rx_bit_q   <= '0;
               rx_state_q <= rx_s_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_tick) begin
               rx_cnt_q   <= '0;
               rx_shift_q <= {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
               rx_bit_q   <= rx_bit_q + BIT_W'(1);
`ifdef UART_LOOPBACK_PARITY_EN
               if (rx_bit_q == BIT_END) rx_state_q <= RX_PARITY;
`else
               if (rx_bit_q == BIT_END) rx_state_q <= RX_STOP;
`endif
            end
`ifdef UART_LOOPBACK_PARITY_EN
            RX_PARITY: if (rx_tick) begin
               rx_cnt_q     <= '0;
               rx_par_bad_q <= rx_s_q != parity_bit(9'(rx_shift_q), 1'(PARITY_ODD));
               rx_state_q   <= RX_STOP;
            end
`endif
            RX_STOP: if (rx_tick) begin
               rx_state_q <= RX_IDLE;
               if (!rx_s_q) frame_err_q <= 1'b1;
`ifdef UART_LOOPBACK_PARITY_EN
               else if (rx_par_bad_q) parity_err_q <= 1'b1;
`endif
               else begin
                  rx_vld_q  <= 1'b1;
                  rx_data_q <= rx_shift_q;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   logic                   fifo_full, fifo_empty, tx_pop;
   logic [DATA_BITS-1:0]   fifo_rd_data;
   logic                   overflow_q, overflow_d;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (rx_vld_q),
      .push_data (rx_data_q),
      .pop       (tx_pop),
      .pop_data  (fifo_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      overflow_d = overflow_q | (rx_vld_q & fifo_full & ~tx_pop);
   end

   always_ff @(posedge clock) begin
      if (reset) overflow_q <= 1'b0;
      else       overflow_q <= overflow_d;
   end

   tx_state_e              tx_state_q;
   logic [CNT_W-1:0]       tx_cnt_q;
   logic [BIT_W-1:0]       tx_bit_q;
   logic [DATA_BITS-1:0]   tx_shift_q;
   logic                   txd_q, tx_tick;
`ifdef UART_LOOPBACK_PARITY_EN
   logic                   tx_par_q;
`endif

   assign tx_pop  = (tx_state_q == TX_IDLE) && !fifo_empty && !tx_pause;
   assign tx_tick = tx_cnt_q == CNT_END;

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
`ifdef UART_LOOPBACK_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + CNT_W'(1);
         unique case (tx_state_q)
            TX_IDLE: begin
               tx_cnt_q <= '0;
               if (tx_pop) begin
                  tx_shift_q <= fifo_rd_data;
`ifdef UART_LOOPBACK_PARITY_EN
                  tx_par_q   <= parity_bit(9'(fifo_rd_data), 1'(PARITY_ODD));
`endif
                  txd_q      <= 1'b0;
                  tx_state_q <= TX_START;
               end
            end
            TX_START: if (tx_tick) begin
               tx_bit_q   <= '0;
               txd_q      <= tx_shift_q[0];
               tx_state_q <= TX_DATA;
            end
            TX_DATA: if (tx_tick) begin
               tx_bit_q <= tx_bit_q + BIT_W'(1);
               if (tx_bit_q == BIT_END) begin
`ifdef UART_LOOPBACK_PARITY_EN
                  txd_q      <= tx_par_q;
                  tx_state_q <= TX_PARITY;
`else
                  txd_q      <= 1'b1;
                  tx_state_q <= TX_STOP;
`endif
               end else begin
                  tx_shift_q <= tx_shift_q >> 1;
                  txd_q      <= tx_shift_q[1];
               end
            end
`ifdef UART_LOOPBACK_PARITY_EN
            TX_PARITY: if (tx_tick) begin
               txd_q      <= 1'b1;
               tx_state_q <= TX_STOP;
            end
`endif
            TX_STOP: if (tx_tick) tx_state_q <= TX_IDLE;
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   assign txd       = txd_q;
   assign tx_rdy    = tx_state_q == TX_IDLE;
   assign rx_vld    = rx_vld_q;
   assign rx_data   = rx_data_q;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;
`ifdef UART_LOOPBACK_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
